scan_sequencer: RTL and testbench

//  Parametrised timing generator for LED-matrix row scanning; successor to the fixed modulo counter.

---
 rtl/scan_pkg.sv | 20 ++
 rtl/mod_counter.sv | 43 ++++
 rtl/scan_sequencer.sv | 107 ++++++++++
 tb/tb_scan_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared sizing helpers and default types for the LED-matrix scan sequencer.
// Consumers: mod_counter, scan_sequencer (optional blanking via SCAN_BLANKING_EN).
package scan_pkg;

    // Counter width for a modulus n: at least one bit, even when n is 1 or 2.
    function automatic int cw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Default geometry of the panel this sequencer was sized for.
    localparam int DEF_PRESCALE     = 6;
    localparam int DEF_ROWS         = 16;
    localparam int DEF_PLANES       = 8;
    localparam int DEF_BLANK_CYCLES = 2;

    // Row / plane index types for the default geometry, for use by the matrix driver.
    typedef logic [cw(DEF_ROWS)-1:0]   row_t;
    typedef logic [cw(DEF_PLANES)-1:0] plane_t;

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD counter with synchronous reset/clear, advance enable and wrap flag.
// wrap is combinational and marks the cycle in which the counter steps from MOD-1 to 0.
module mod_counter
    import scan_pkg::*;
#(
    parameter  int MOD = 2,
    localparam int W   = cw(MOD)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic         wrap
);

    // Full-width terminal value so non-power-of-two moduli never overrun.
    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    // Next count: advance on inc, folding back to zero after the terminal value.
    always_comb begin
        value_d = value_q;
        if (inc) begin
            value_d = (value_q == LAST) ? '0 : value_q + 1'b1;
        end
    end

    // Count register; reset and clear both restart from zero.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign wrap  = inc && (value_q == LAST);

endmodule

// File: rtl/scan_sequencer.sv
// Row-scan timing generator: prescaler -> row index -> bit-plane index.
// Optional feature macro: SCAN_BLANKING_EN adds a blank window of BLANK_CYCLES
// enabled cycles after every row change; without it blank is tied low.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter  int PRESCALE     = DEF_PRESCALE,
    parameter  int ROWS         = DEF_ROWS,
    parameter  int PLANES       = DEF_PLANES,
    parameter  int BLANK_CYCLES = DEF_BLANK_CYCLES,
    localparam int RW           = cw(ROWS),
    localparam int FW           = cw(PLANES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clear,
    output logic          tick,
    output logic [RW-1:0] row,
    output logic          row_wrap,
    output logic [FW-1:0] plane,
    output logic          frame_wrap,
    output logic          blank
);

    localparam int PW = cw(PRESCALE);
    localparam int BW = cw(BLANK_CYCLES + 1);

    // Only the prescaler wrap matters outside; its count stays internal.
    logic [PW-1:0] pcnt_unused;
    logic          pre_wrap;
    logic          row_wrap_raw;
    logic          frame_wrap_raw;

    // A restart cycle must not emit flags for the abandoned partial frame.
    logic          restart;
    assign restart = rst || clear;

    mod_counter #(.MOD(PRESCALE)) u_prescale (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .inc   (en),
        .value (pcnt_unused),
        .wrap  (pre_wrap)
    );

    assign tick = pre_wrap && !restart;

    mod_counter #(.MOD(ROWS)) u_row (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .inc   (tick),
        .value (row),
        .wrap  (row_wrap_raw)
    );

    // tick is already gated, so the cascaded flags inherit the restart gating.
    assign row_wrap = row_wrap_raw;

    mod_counter #(.MOD(PLANES)) u_plane (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .inc   (row_wrap),
        .value (plane),
        .wrap  (frame_wrap_raw)
    );

    assign frame_wrap = frame_wrap_raw;

`ifdef SCAN_BLANKING_EN
    localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYCLES);

    logic [BW-1:0] bcnt_q;
    logic [BW-1:0] bcnt_d;

    // Blank countdown: reload on each row change, drain one per enabled cycle.
    always_comb begin
        bcnt_d = bcnt_q;
        if (tick) begin
            bcnt_d = BLANK_LOAD;
        end else if (en && (bcnt_q != '0)) begin
            bcnt_d = bcnt_q - 1'b1;
        end
    end

    // Blank counter register; a restart opens a fresh blank window.
    always_ff @(posedge clk) begin
        if (restart) begin
            bcnt_q <= BLANK_LOAD;
        end else begin
            bcnt_q <= bcnt_d;
        end
    end

    // Restart cycles blank immediately, even when BLANK_CYCLES is zero.
    assign blank = restart || (bcnt_q != '0);
`else
    // Keeps the blank-length parameter referenced when the window is compiled out.
    logic [BW-1:0] blank_len_unused;
    assign blank_len_unused = BW'(BLANK_CYCLES);
    assign blank            = 1'b0;
`endif

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer: a table of vectors on a tiny
// configuration plus scoreboarded sequences on the default geometry.
module tb_scan_sequencer;
    import scan_pkg::*;

    localparam int P  = 6;
    localparam int R  = 16;
    localparam int PL = 8;
    localparam int BL = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (default geometry)
    logic       rst, en, clear;
    logic       tick, row_wrap, frame_wrap, blank;
    logic [3:0] row;
    logic [2:0] plane;

    // Small DUT (PRESCALE=1, ROWS=3, PLANES=1)
    logic       rst2, en2, clear2;
    logic       tick2, row_wrap2, frame_wrap2, blank2;
    logic [1:0] row2;
    logic [0:0] plane2;

    scan_sequencer #(.PRESCALE(P), .ROWS(R), .PLANES(PL), .BLANK_CYCLES(BL)) dut (
        .clk(clk), .rst(rst), .en(en), .clear(clear),
        .tick(tick), .row(row), .row_wrap(row_wrap),
        .plane(plane), .frame_wrap(frame_wrap), .blank(blank)
    );

    scan_sequencer #(.PRESCALE(1), .ROWS(3), .PLANES(1), .BLANK_CYCLES(0)) dut_small (
        .clk(clk), .rst(rst2), .en(en2), .clear(clear2),
        .tick(tick2), .row(row2), .row_wrap(row_wrap2),
        .plane(plane2), .frame_wrap(frame_wrap2), .blank(blank2)
    );

    typedef struct packed {
        logic       tick;
        logic [3:0] row;
        logic       row_wrap;
        logic [2:0] plane;
        logic       frame_wrap;
        logic       blank;
    } obs_t;

    typedef struct {
        logic       en;
        logic       clr;
        logic       rs;
        logic       tick;
        logic [1:0] row;
        logic       rw;
        logic       fw;
    } vec_t;

    obs_t exp_q[$];
    obs_t last_obs;
    int   checks = 0;
    int   errors = 0;
    int   n  = 0;   // enabled cycles since last restart (reference model)
    int   bm = 0;   // reference blank countdown

    task automatic check_int(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic check_obs(input string name, input obs_t act, input obs_t expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s @%0t: got tick=%0b row=%0d rw=%0b plane=%0d fw=%0b blank=%0b, expected tick=%0b row=%0d rw=%0b plane=%0d fw=%0b blank=%0b",
                     name, $time, act.tick, act.row, act.row_wrap, act.plane, act.frame_wrap, act.blank,
                     expv.tick, expv.row, expv.row_wrap, expv.plane, expv.frame_wrap, expv.blank);
        end
    endtask

    // Expected outputs derived from the enabled-cycle count since the last restart.
    function automatic obs_t model(input logic e, input logic c, input logic r);
        obs_t o;
        int   pc;
        pc           = n % P;
        o.row        = 4'((n / P) % R);
        o.plane      = 3'((n / (P * R)) % PL);
        o.tick       = e && !c && !r && (pc == P - 1);
        o.row_wrap   = o.tick && (o.row == 4'(R - 1));
        o.frame_wrap = o.row_wrap && (o.plane == 3'(PL - 1));
`ifdef SCAN_BLANKING_EN
        o.blank      = r || c || (bm != 0);
`else
        o.blank      = 1'b0;
`endif
        return o;
    endfunction

    // One main-DUT cycle: drive, push expectation, sample at negedge, compare, advance model.
    task automatic step(input logic e, input logic c, input logic r, input string name);
        obs_t act;
        logic t;
        en    = e;
        clear = c;
        rst   = r;
        exp_q.push_back(model(e, c, r));
        @(negedge clk);
        act = {tick, row, row_wrap, plane, frame_wrap, blank};
        check_obs(name, act, exp_q.pop_front());
        last_obs = act;
        t = e && !c && !r && ((n % P) == P - 1);
        if (r || c)           bm = BL;
        else if (t)           bm = BL;
        else if (e && bm != 0) bm = bm - 1;
        if (r || c)  n = 0;
        else if (e)  n = n + 1;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[13];

    initial begin
        int   fw_cnt;
        int   fw_at;
        int   lat;
        logic found;
        logic eb;
        logic cb;
        logic exp_blank2;

        // Tiny-config vectors: {en, clear, rst, tick, row, row_wrap, frame_wrap}
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};

        rst = 1'b1; en = 1'b0; clear = 1'b0;
        rst2 = 1'b1; en2 = 1'b0; clear2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // T2: tiny configuration, main DUT held in reset meanwhile
        for (int i = 0; i < 13; i++) begin
            en2 = vecs[i].en; clear2 = vecs[i].clr; rst2 = vecs[i].rs;
            @(negedge clk);
`ifdef SCAN_BLANKING_EN
            exp_blank2 = vecs[i].clr || vecs[i].rs;
`else
            exp_blank2 = 1'b0;
`endif
            checks++;
            if ({tick2, row2, row_wrap2, frame_wrap2, plane2, blank2} !==
                {vecs[i].tick, vecs[i].row, vecs[i].rw, vecs[i].fw, 1'b0, exp_blank2}) begin
                errors++;
                $display("FAIL vec%0d: got tick=%0b row=%0d rw=%0b fw=%0b plane=%0d blank=%0b, expected tick=%0b row=%0d rw=%0b fw=%0b plane=0 blank=%0b",
                         i, tick2, row2, row_wrap2, frame_wrap2, plane2, blank2,
                         vecs[i].tick, vecs[i].row, vecs[i].rw, vecs[i].fw, exp_blank2);
            end else begin
                $display("vec%0d en=%0b clr=%0b rst=%0b -> tick=%0b row=%0d rw=%0b fw=%0b ok",
                         i, vecs[i].en, vecs[i].clr, vecs[i].rs, tick2, row2, row_wrap2, frame_wrap2);
            end
            @(posedge clk);
            #1;
        end

        // Reset state of the main DUT
        step(1'b0, 1'b0, 1'b1, "reset");
        $display("reset: row=%0d plane=%0d tick=%0b blank=%0b", row, plane, tick, blank);

        // T1: one full frame of enabled cycles
        fw_cnt = 0; fw_at = 0;
        for (int c = 1; c <= P * R * PL; c++) begin
            step(1'b1, 1'b0, 1'b0, "T1");
            if (last_obs.frame_wrap) begin
                fw_cnt++;
                fw_at = c;
            end
        end
        check_int("T1_frame_wrap_count", fw_cnt, 1);
        check_int("T1_frame_wrap_cycle", fw_at, P * R * PL);
        $display("T1: frame_wrap count=%0d at cycle %0d", fw_cnt, fw_at);

        // T3: pause at prescaler count 3, resume, next tick after 3 enabled cycles
        repeat (3) step(1'b1, 1'b0, 1'b0, "T3_pre");
        repeat (10) step(1'b0, 1'b0, 1'b0, "T3_hold");
        found = 1'b0; lat = 0;
        for (int i = 1; i <= 10 && !found; i++) begin
            step(1'b1, 1'b0, 1'b0, "T3_resume");
            if (last_obs.tick) begin
                found = 1'b1;
                lat   = i;
            end
        end
        check_int("T3_resume_latency", lat, 3);
        $display("T3: tick %0d enabled cycles after resume", lat);

        // T4: clear on the tick cycle at row 7, plane 2
        for (int i = 0; i < 1000 && (n % (P * R * PL)) != (2 * P * R + 7 * P + P - 1); i++) begin
            step(1'b1, 1'b0, 1'b0, "T4_run");
        end
        step(1'b1, 1'b1, 1'b0, "T4_clear");
        check_int("T4_row_at_clear", int'(last_obs.row), 7);
        check_int("T4_plane_at_clear", int'(last_obs.plane), 2);
        check_int("T4_tick_at_clear", int'(last_obs.tick), 0);
        step(1'b0, 1'b0, 1'b0, "T4_after");
        check_int("T4_row_after", int'(last_obs.row), 0);
        check_int("T4_plane_after", int'(last_obs.plane), 0);
        $display("T4: clear at row 7 plane 2 -> row=%0d plane=%0d", last_obs.row, last_obs.plane);

        // T5: rst together with clear and en mid-frame
        repeat (50) step(1'b1, 1'b0, 1'b0, "T5_run");
        step(1'b1, 1'b1, 1'b1, "T5_rst");
        step(1'b0, 1'b0, 1'b0, "T5_after");
        check_int("T5_row_after", int'(last_obs.row), 0);
        check_int("T5_plane_after", int'(last_obs.plane), 0);
        $display("T5: after rst row=%0d plane=%0d", last_obs.row, last_obs.plane);

        // Mixed traffic: random enable gaps and occasional clears
        for (int i = 0; i < 400; i++) begin
            eb = ($urandom_range(0, 3) != 0);
            cb = ($urandom_range(0, 60) == 0);
            step(eb, cb, 1'b0, "random");
        end
        $display("random: 400 cycles applied");

        // T6: blank follows each tick for BLANK_CYCLES enabled cycles
        for (int i = 0; i < 2 * P; i++) begin
            step(1'b1, 1'b0, 1'b0, "T6_blank");
        end
        $display("T6: blank window sequence applied");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always reaches a conclusion.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

endmodule
